// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and Gray-code helpers.
// Reused by both the read-side and write-side controllers.
package fifo_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int PTR_BITS    = 7;

   typedef logic [PTR_BITS-1:0] ptr_t;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer.
// Safe only because the source changes at most one bit per source clock.
module gray_ptr_sync
   import fifo_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] grayAsync,
   output logic [WIDTH-1:0] graySync
);

   logic [WIDTH-1:0] stages [SYNC_STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stages[i] <= '0;
         end
      end else begin
         stages[0] <= grayAsync;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign graySync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO (rdClk domain).
// Issues memory reads into a 2-entry output buffer with valid/ready.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 64,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  rdClk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH:0]   wrPtrGray,
   output logic [ADDR_WIDTH:0]   rdPtrGray,
   output logic                  readEn,
   output logic [ADDR_WIDTH-1:0] addrOut,
   input  logic [FIFO_WIDTH-1:0] memDataOut,
   output logic [FIFO_WIDTH-1:0] dataOut,
   output logic                  dataValid,
   input  logic                  dataReady,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   rdLevel
);

   typedef logic [ADDR_WIDTH:0] ptrw_t;

   if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : gBadDepth
      $error("FIFO_DEPTH must equal 2**ADDR_WIDTH");
   end

   ptrw_t wrGraySync;
   ptrw_t wrBinSync;
   ptrw_t rdBin;
   ptrw_t rdBinNext;

   logic [1:0]            occ;
   logic                  infl;
   logic                  pop;
   logic [2:0]            pending;
   logic [FIFO_WIDTH-1:0] headQ;
   logic [FIFO_WIDTH-1:0] tailQ;

   gray_ptr_sync #(
      .WIDTH     (ADDR_WIDTH + 1)
   ) uWrSync (
      .clk       (rdClk),
      .rst       (rst),
      .grayAsync (wrPtrGray),
      .graySync  (wrGraySync)
   );

   assign wrBinSync = ptrw_t'(gray2bin(32'(wrGraySync)));
   assign rdBinNext = rdBin + ptrw_t'(1);

   assign empty   = (rdPtrGray == wrGraySync);
   assign rdLevel = wrBinSync - rdBin;
   assign addrOut = rdBin[ADDR_WIDTH-1:0];

   assign dataValid = (occ != 2'd0);
   assign dataOut   = headQ;
   assign pop       = dataValid && dataReady;

   // Count the in-flight word so the buffer can never overflow.
   assign pending = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
   assign readEn  = !empty && (pending < 3'd2);

   always_ff @(posedge rdClk or posedge rst) begin
      if (rst) begin
         rdBin     <= '0;
         rdPtrGray <= '0;
      end else if (readEn) begin
         rdBin     <= rdBinNext;
         rdPtrGray <= ptrw_t'(bin2gray(32'(rdBinNext)));
      end
   end

   always_ff @(posedge rdClk or posedge rst) begin
      if (rst) begin
         occ   <= '0;
         infl  <= 1'b0;
         headQ <= '0;
         tailQ <= '0;
      end else begin
         infl <= readEn;
         case ({infl, pop})
            2'b11: begin
               if (occ == 2'd2) begin
                  headQ <= tailQ;
                  tailQ <= memDataOut;
               end else begin
                  headQ <= memDataOut;
               end
            end
            2'b10: begin
               if (occ == 2'd0) begin
                  headQ <= memDataOut;
               end else begin
                  tailQ <= memDataOut;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               headQ <= tailQ;
               occ   <= occ - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl with a behavioural memory
// and a write side driven directly from the bench.
module tb_fifo_rd_ctrl;
   import fifo_pkg::*;

   localparam int W  = 8;
   localparam int D  = 64;
   localparam int AW = 6;

   logic          rdClk = 1'b0;
   logic          rst;
   ptr_t          wrPtrGray;
   ptr_t          rdPtrGray;
   logic          readEn;
   logic [AW-1:0] addrOut;
   logic [W-1:0]  memDataOut;
   logic [W-1:0]  dataOut;
   logic          dataValid;
   logic          dataReady;
   logic          empty;
   logic [AW:0]   rdLevel;

   always #5 rdClk = ~rdClk;

   fifo_rd_ctrl #(
      .FIFO_WIDTH (W),
      .FIFO_DEPTH (D),
      .ADDR_WIDTH (AW)
   ) dut (
      .rdClk      (rdClk),
      .rst        (rst),
      .wrPtrGray  (wrPtrGray),
      .rdPtrGray  (rdPtrGray),
      .readEn     (readEn),
      .addrOut    (addrOut),
      .memDataOut (memDataOut),
      .dataOut    (dataOut),
      .dataValid  (dataValid),
      .dataReady  (dataReady),
      .empty      (empty),
      .rdLevel    (rdLevel)
   );

   logic [W-1:0] mem [D];

   always @(posedge rdClk) begin
      if (readEn) memDataOut <= mem[addrOut];
   end

   int           nChk = 0;
   int           nFail = 0;
   logic [W-1:0] q [$];
   ptr_t         wrBin;
   int           cyc = 0;
   int           reCount = 0;
   int           popCount = 0;
   int           firstPop = 0;
   int           lastPop = 0;
   int           validCount = 0;
   logic         sawWrap = 1'b0;
   logic         prevRst = 1'b1;
   ptr_t         prevGray = '0;
   logic         prevHold = 1'b0;
   logic [W-1:0] prevData = '0;
   logic [AW-1:0] prevAddr = '0;
   logic [W-1:0] expV;

   function automatic ptr_t g(input int b);
      ptr_t v;
      v = ptr_t'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nChk++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge rdClk) begin
      cyc++;
      if (!rst) begin
         if (readEn) reCount++;
         if (dataValid) validCount++;
         if (!prevRst && prevAddr == 6'd63 && addrOut == 6'd0) sawWrap = 1'b1;
         chk("rdEnWhileEmpty", 32'(readEn && empty), 0);
         chk("levelBound", 32'(rdLevel <= 7'(D)), 1);
         if (!prevRst) begin
            chk("grayStep", 32'($countones(rdPtrGray ^ prevGray) <= 1), 1);
            if (prevHold) chk("holdData", 32'(dataOut), 32'(prevData));
         end
         if (dataValid && dataReady) begin
            chk("sbNonEmpty", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               expV = q.pop_front();
               chk("sbData", 32'(dataOut), 32'(expV));
               if (popCount == 0) firstPop = cyc;
               lastPop = cyc;
               popCount++;
            end
         end
      end
      prevRst  = rst;
      prevGray = rdPtrGray;
      prevHold = dataValid && !dataReady;
      prevData = dataOut;
      prevAddr = addrOut;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge rdClk);
         #1;
      end
   endtask

   task automatic doReset();
      rst       = 1'b1;
      wrBin     = '0;
      wrPtrGray = '0;
      dataReady = 1'b0;
      q.delete();
      repeat (2) @(posedge rdClk);
      #1 rst = 1'b0;
   endtask

   task automatic writeWord(input logic [W-1:0] v);
      mem[wrBin[AW-1:0]] = v;
      q.push_back(v);
      wrBin     = wrBin + ptr_t'(1);
      wrPtrGray = g(int'(wrBin));
      tick(1);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((q.size() != 0 || dataValid) && k < 300) begin
         tick(1);
         k++;
      end
      chk("drainDone", 32'(q.size() == 0 && !dataValid), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      doReset();
      dataReady = 1'b1;
      chk("rstGray", 32'(rdPtrGray), 0);
      chk("rstEmpty", 32'(empty), 1);
      chk("rstLevel", 32'(rdLevel), 0);
      chk("rstReadEn", 32'(readEn), 0);
      chk("rstAddr", 32'(addrOut), 0);
      chk("rstValid", 32'(dataValid), 0);
      chk("rstData", 32'(dataOut), 0);

      // single word latency
      mem[0] = 8'hA5;
      q.push_back(8'hA5);
      wrBin = ptr_t'(1);
      wrPtrGray = g(1);
      tick(1);
      chk("e1Empty", 32'(empty), 1);
      tick(1);
      chk("e2Empty", 32'(empty), 0);
      chk("e2ReadEn", 32'(readEn), 1);
      chk("e2Level", 32'(rdLevel), 1);
      tick(1);
      chk("e3ReadEn", 32'(readEn), 0);
      chk("e3Gray", 32'(rdPtrGray), 32'(g(1)));
      chk("e3Empty", 32'(empty), 1);
      chk("e3Valid", 32'(dataValid), 0);
      tick(1);
      chk("e4Valid", 32'(dataValid), 1);
      chk("e4Data", 32'(dataOut), 32'h00A5);
      tick(1);
      chk("e5Valid", 32'(dataValid), 0);
      chk("e5Empty", 32'(empty), 1);

      // full-depth streaming
      doReset();
      dataReady = 1'b1;
      popCount  = 0;
      sawWrap   = 1'b0;
      for (int i = 0; i < D; i++) writeWord(W'(i));
      drain();
      chk("strmPops", 32'(popCount), 64);
      chk("strmSpan", 32'(lastPop - firstPop), 63);
      chk("strmWrap", 32'(sawWrap), 1);
      chk("strmGray", 32'(rdPtrGray), 32'(g(64)));

      // back-pressure
      doReset();
      reCount = 0;
      for (int i = 0; i < 10; i++) writeWord(W'(8'h30 + i));
      tick(6);
      chk("bpReads", 32'(reCount), 2);
      chk("bpOcc", 32'(dut.occ), 2);
      chk("bpLevel", 32'(rdLevel), 8);
      chk("bpValid", 32'(dataValid), 1);
      chk("bpHead", 32'(dataOut), 32'h30);
      tick(3);
      chk("bpHeld", 32'(dataOut), 32'h30);
      chk("bpReadEn", 32'(readEn), 0);
      dataReady = 1'b1;
      drain();

      // pointer wrap 127 -> 0
      doReset();
      dataReady = 1'b1;
      for (int i = 0; i < 125; i++) writeWord(W'(i * 7 + 3));
      drain();
      chk("wrapGray125", 32'(rdPtrGray), 32'(g(125)));
      dataReady = 1'b0;
      writeWord(8'hC1);
      writeWord(8'hC2);
      tick(6);
      chk("wrapOcc", 32'(dut.occ), 2);
      chk("wrapLevel0", 32'(rdLevel), 0);
      chk("wrapGray127", 32'(rdPtrGray), 32'(g(127)));
      writeWord(8'hD1);
      writeWord(8'hD2);
      writeWord(8'hD3);
      tick(4);
      chk("wrapLevel3", 32'(rdLevel), 3);
      dataReady = 1'b1;
      tick(1);
      chk("wrapLevel2", 32'(rdLevel), 2);
      tick(1);
      chk("wrapLevel1", 32'(rdLevel), 1);
      tick(1);
      chk("wrapLevelZ", 32'(rdLevel), 0);
      drain();
      chk("wrapGray2", 32'(rdPtrGray), 32'(g(2)));

      // reset while a read is in flight
      doReset();
      writeWord(8'h11);
      writeWord(8'h22);
      begin
         int k;
         k = 0;
         while (!(dut.infl && dut.occ == 2'd1) && k < 20) begin
            tick(1);
            k++;
         end
         chk("midReach", 32'(dut.infl && dut.occ == 2'd1), 1);
      end
      rst = 1'b1;
      #1;
      chk("midValid", 32'(dataValid), 0);
      chk("midData", 32'(dataOut), 0);
      chk("midGray", 32'(rdPtrGray), 0);
      chk("midReadEn", 32'(readEn), 0);
      chk("midAddr", 32'(addrOut), 0);
      chk("midLevel", 32'(rdLevel), 0);
      chk("midEmpty", 32'(empty), 1);
      q.delete();
      wrBin = '0;
      wrPtrGray = '0;
      tick(2);
      rst = 1'b0;
      dataReady = 1'b1;
      validCount = 0;
      tick(10);
      chk("midNoStale", 32'(validCount), 0);
      chk("midEmptyAfter", 32'(empty), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChk, nFail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the dual-clock FIFO, living entirely in the `rdClk` domain and driving the read port of the dual-port memory. It synchronizes the Gray-coded write pointer from the write domain, derives empty status and fill level, and issues memory reads (`readEn`/`addrOut`). Read data goes to a 2-entry output buffer and is presented on a valid/ready handshake. It also returns its own Gray-coded read pointer to the write-side controller for full detection.

## Interface
- `FIFO_WIDTH`, 8, data word width
- `FIFO_DEPTH`, 64, memory words; must equal 2**`ADDR_WIDTH` (elaboration error otherwise)
- `ADDR_WIDTH`, 6, memory address width; pointers are `ADDR_WIDTH+1` bits
- Clocking: one clock, `rdClk`; reset `rst` is asynchronous and active-high.
- `rdClk`  in  1  read-domain clock; all state updates on its rising edge
- `rst`  in  1  asynchronous active-high reset
- `wrPtrGray`  in  ADDR_WIDTH+1  Gray write pointer from the `wrClk` domain; changes at most one bit per `wrClk`
- `rdPtrGray`  out  ADDR_WIDTH+1  registered Gray read pointer, to the write side
- `readEn`  out  1  memory read strobe (combinational)
- `addrOut`  out  ADDR_WIDTH  memory read address; equals the low bits of the binary read pointer
- `memDataOut`  in  FIFO_WIDTH  memory read data; valid after the `rdClk` edge that sampled `readEn`
- `dataOut`  out  FIFO_WIDTH  head word of the output buffer
- `dataValid`  out  1  `dataOut` holds a word
- `dataReady`  in  1  consumer accepts; a pop occurs when `dataValid && dataReady`
- `empty`  out  1  no unread words in memory (synchronized view); buffered words are not counted
- `rdLevel`  out  ADDR_WIDTH+1  words in memory per synchronized view, range 0..FIFO_DEPTH

## Operation
- Synchronizer: two flops on `wrPtrGray` produce `wrGraySync`, which is converted to binary `wrBinSync`. No other logic samples `wrPtrGray`.
- Memory empty: `empty = (rdPtrGray == wrGraySync)`.
- Fill level: `rdLevel = (wrBinSync - rdBin)` modulo 2**(ADDR_WIDTH+1).
- Output buffer: 2-entry register FIFO, count `occ` (0..2). An in-flight flag `infl` is set for one cycle after each issued read.
- Read issue: `readEn = !empty && (occ + infl - pop) < 2`.
  - On a `readEn` edge: `rdBin` increments by 1, wrapping at 2**(ADDR_WIDTH+1); `rdPtrGray` updates to bin2gray of the new value; `infl` is set.
  - On the next edge: `memDataOut` is written into the buffer tail and `infl` clears.
- Simultaneous capture and pop: `occ` is unchanged and the head advances.
- Ordering is strict FIFO. Read addresses are issued sequentially, wrapping from `FIFO_DEPTH-1` to 0.
- `dataOut`/`dataValid` come from buffer registers, never directly from `memDataOut`. `dataOut` is stable while `dataValid && !dataReady`.

## Timing
- Reset values:
  - `rdPtrGray`=0, `rdBin`=0, synchronizer flops=0
  - `occ`=0, `infl`=0
  - `dataValid`=0, `dataOut`=0
  - `empty`=1, `rdLevel`=0, `readEn`=0, `addrOut`=0
- Reset mid-operation: the in-flight read and the buffer contents are discarded. Reset is sampled asynchronously and released synchronously, with deassertion aligned to `rdClk` externally.
- Latency, with `wrPtrGray` changing from empty state before edge E1:
  - `empty` falls after E2.
  - `readEn`=1 during E2→E3.
  - Buffer captures at E4.
  - `dataValid`=1 after E4.
- Throughput: 1 word/cycle sustained while `dataReady`=1 and `empty`=0.
- Back-pressure: with `dataReady`=0, at most 2 words are buffered. `readEn` stays 0 until a pop.
- `readEn` depends combinationally on `dataReady`. All other outputs are registered or decoded from registers only.

## Structure
- Shared package `fifo_pkg` holds:
  - typedef `ptr_t` (ADDR_WIDTH+1 bits)
  - functions `bin2gray` and `gray2bin`
  - constant `SYNC_STAGES`=2
  - These are reused by the write-side controller.
- Sub-module `gray_ptr_sync`: a parameterized-width `SYNC_STAGES`-flop synchronizer with async reset. It is instantiated once here and once on the write side.

## Test plan
- Reset, then `wrPtrGray`=bin2gray(1), memory word 0 = 8'hA5, `dataReady`=1:
  - `empty` falls after 2 edges
  - `dataValid`=1 with `dataOut`=8'hA5 after 4 edges
  - `rdPtrGray`=bin2gray(1)
  - `empty`=1 afterwards
- `wrPtrGray` stepped to 64 with words 0..63 = address value, `dataReady`=1:
  - 64 consecutive pops of values 0..63, one per cycle
  - `addrOut` wraps 63→0
  - `rdPtrGray`=bin2gray(64)
- 10 words available, `dataReady`=0:
  - exactly 2 reads issued, `occ`=2, `rdLevel`=8
  - `dataOut` is held stable
  - raising `dataReady` drains all 10 in order
- Pointer wrap: preload `rdBin`/`wrPtrGray` to 127 and write 3 more words:
  - reads continue across the 127→0 wrap with correct data
  - `rdLevel` reads 3, then 2, 1, 0
- Assert `rst` while `infl`=1 and `occ`=1:
  - all outputs return to reset values immediately
  - no stale word appears after release
- Assertions bound in the bench:
  - `readEn` never asserted while `empty`=1
  - `rdPtrGray` changes at most 1 bit per edge
  - `dataOut` stable under back-pressure
  - `rdLevel` ≤ `FIFO_DEPTH`
